seq_pattern_detector: RTL and testbench

- Parametrised serial bit-pattern detector. Successor to the fixed-pattern sequence detector.
- Pattern length is set by a parameter. The pattern and the overlap mode are loaded at run time.
- Input bits are qualified by a valid strobe, and a saturating match counter is kept.
- Sits on a serial data path; other blocks use it for frame-sync or marker detection.

---
 rtl/seq_pattern_detector.sv | 109 ++++++++++
 tb/tb_seq_pattern_detector.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//   Serial bit-pattern detector with a run-time loadable pattern and overlap
//   mode. Input bits are qualified by in_valid. A saturating counter tracks
//   the number of matches.
//
//   Optional build macro: SEQ_PATTERN_DETECTOR_MASK_EN
//     When it is defined, the block adds the cfg_mask input and a mask
//     register. Mask bits that are 0 are don't-care in the comparison.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   in           serial data bit
//   in_valid     qualifies in
//   cfg_load     loads cfg_pattern / cfg_overlap (and cfg_mask), clears history
//   cfg_pattern  new pattern, bit LEN-1 is the oldest bit
//   cfg_overlap  new overlap mode (1 = overlapping)
//   cfg_mask     (MASK_EN only) new compare mask, 1 = bit must match
//   out          one-cycle registered match pulse
//   match_count  saturating match count
//   fill         number of valid history bits, 0..LEN
module seq_pattern_detector #(
    parameter int             LEN         = 4,
    parameter int             CNT_W       = 8,
    parameter logic [LEN-1:0] RST_PATTERN = LEN'(4'b1011),
    parameter bit             RST_OVERLAP = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in,
    input  logic                       in_valid,
    input  logic                       cfg_load,
    input  logic [LEN-1:0]             cfg_pattern,
    input  logic                       cfg_overlap,
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
    input  logic [LEN-1:0]             cfg_mask,
`endif
    output logic                       out,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(LEN+1)-1:0]   fill
);

    localparam int FW = $clog2(LEN+1);
    localparam logic [FW-1:0] FULL = FW'(LEN);

    logic [LEN-1:0] hist;
    logic [LEN-1:0] pattern;
    logic           overlap;
    logic [LEN-1:0] hist_n;
    logic [FW-1:0]  fill_n;
    logic           hit;
    logic           match;

`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
    logic [LEN-1:0] mask;

    always_ff @(posedge clock) begin
        if (reset)
            mask <= '1;
        else if (cfg_load)
            mask <= cfg_mask;
    end

    assign hit = ((hist_n ^ pattern) & mask) == '0;
`else
    assign hit = (hist_n == pattern);
`endif

    // Next history and fill if the current bit is accepted. The fill
    // requirement stops zero bits left over from reset or load from
    // completing a match.
    always_comb begin
        hist_n = {hist[LEN-2:0], in};
        fill_n = (fill == FULL) ? FULL : fill + FW'(1);
        match  = (fill_n == FULL) && hit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
            pattern     <= RST_PATTERN;
            overlap     <= RST_OVERLAP;
        end else if (cfg_load) begin
            // A new pattern invalidates the history. The count is kept.
            pattern <= cfg_pattern;
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            out     <= 1'b0;
        end else if (in_valid) begin
            hist <= hist_n;
            out  <= match;
            if (match) begin
                // In non-overlap mode the next match needs LEN fresh bits.
                fill <= overlap ? FULL : '0;
                if (match_count != {CNT_W{1'b1}})
                    match_count <= match_count + CNT_W'(1);
            end else begin
                fill <= fill_n;
            end
        end else begin
            out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Testbench for seq_pattern_detector: directed scenarios plus random traffic.
// The reference model keeps a queue of the bits accepted since the last
// reset, load, or non-overlapping match, and compares the newest LEN of them.
module tb_seq_pattern_detector;
    localparam int LEN   = 4;
    localparam int CNT_W = 8;
    localparam int FW    = $clog2(LEN+1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset, in, in_valid, cfg_load, cfg_overlap;
    logic [LEN-1:0] cfg_pattern;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
    logic [LEN-1:0] cfg_mask;
`endif
    logic             out;
    logic [CNT_W-1:0] match_count;
    logic [FW-1:0]    fill;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_pattern_detector #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .in(in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .out(out), .match_count(match_count), .fill(fill)
    );

    // reference model state
    bit             q[$];
    logic [LEN-1:0] m_pat  = 4'b1011;
    logic [LEN-1:0] m_mask = '1;
    bit             m_ov   = 1'b1;
    bit             m_out  = 1'b0;
    int             m_cnt  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive the inputs, advance the model, then compare out,
    // match_count and fill.
    task automatic step(input bit rst, input bit ld, input bit v, input bit b,
                        input logic [LEN-1:0] pat = '0, input bit ov = 1'b0,
                        input logic [LEN-1:0] msk = '1);
        logic [LEN-1:0] w;
        reset       = rst;
        cfg_load    = ld;
        in_valid    = v;
        in          = b;
        cfg_pattern = pat;
        cfg_overlap = ov;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
        cfg_mask    = msk;
`endif
        @(posedge clock);
        m_out = 1'b0;
        if (rst) begin
            q.delete();
            m_pat = 4'b1011; m_ov = 1'b1; m_mask = '1; m_cnt = 0;
        end else if (ld) begin
            q.delete();
            m_pat = pat; m_ov = ov;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
            m_mask = msk;
`endif
        end else if (v) begin
            q.push_back(b);
            if (q.size() > LEN) void'(q.pop_front());
            if (q.size() == LEN) begin
                for (int i = 0; i < LEN; i++) w[LEN-1-i] = q[i];
                if (((w ^ m_pat) & m_mask) == '0) begin
                    m_out = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                    if (!m_ov) q.delete();
                end
            end
        end
        #1;
        chk("out", int'(out), int'(m_out));
        chk("match_count", int'(match_count), m_cnt);
        chk("fill", int'(fill), q.size());
    endtask

    task automatic bits(input logic [15:0] seq, input int n);
        logic [15:0] s;
        s = seq;
        for (int i = n - 1; i >= 0; i--) step(0, 0, 1, s[i]);
    endtask

    initial begin
        int gaps;
        // reset state
        step(1, 0, 0, 0);
        chk("rst_out", int'(out), 0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_count", int'(match_count), 0);

        // default pattern 1011 with overlap
        bits(16'b1011011, 7);
        chk("dflt_count", int'(match_count), 2);

        // 1010 non-overlapping, then overlapping
        step(1, 0, 0, 0);
        step(0, 1, 1, 1, 4'b1010, 1'b0);
        bits(16'b101010, 6);
        chk("nonovl_count", int'(match_count), 1);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0, 4'b1010, 1'b1);
        bits(16'b101010, 6);
        chk("ovl_count", int'(match_count), 2);

        // gaps in valid are transparent
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] p;
            p = 4'b1011;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) step(0, 0, 0, $urandom_range(0, 1));
            step(0, 0, 1, p[3-i]);
            chk("gap_fill", int'(fill), i + 1);
        end
        chk("gap_out", int'(out), 1);
        step(0, 0, 0, 0);
        chk("gap_out_drop", int'(out), 0);
        chk("gap_count", int'(match_count), 1);

        // reset mid-stream discards partial history
        step(1, 0, 0, 0);
        bits(16'b101, 3);
        step(1, 0, 0, 0);
        bits(16'b1011, 4);
        chk("midrst_count", int'(match_count), 1);

        // saturation
        step(1, 0, 0, 0);
        step(0, 1, 0, 0, 4'b1111, 1'b1);
        for (int i = 0; i < CMAX + 20; i++) step(0, 0, 1, 1);
        chk("sat_count", int'(match_count), CMAX);

        // masked compare, non-overlapping
        step(1, 0, 0, 0);
        step(0, 1, 0, 0, 4'b1001, 1'b0, 4'b1001);
        bits(16'b11111001, 8);
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
        chk("mask_count", int'(match_count), 2);
`else
        chk("mask_count", int'(match_count), 1);
`endif

        // random traffic
        step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                step(1, 0, $urandom_range(0, 1), $urandom_range(0, 1));
            else if ($urandom_range(0, 39) == 0)
                step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1),
                     LEN'($urandom), $urandom_range(0, 1), LEN'($urandom));
            else
                step(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
